// File: rtl/leaper_movegen.sv
// leaper_movegen: Avalon-MM accelerator that generates every pseudo-legal move
// of one leaper piece (knight or king) on a byte-per-square board.
// The CPU programs the source board address, destination base address, square
// (x,y) and mode through the slave port, then writes register 0 to start.
// The master port fetches the source board into a local buffer. It then writes
// one complete successor board per legal move, packed back-to-back from the
// destination base.
//
// Optional feature: define LEAPER_CAPTURE_MASK_EN to make register 7 return a
// capture mask. Bit n of the mask is set when emitted move n captured an
// opposite-colour piece.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   slave_address/read/write     CPU register access (4-bit index)
//   slave_writedata/readdata     32-bit register data
//   slave_waitrequest            held high on a register-0 read until the run ends
//   master_address/read/write    word-aligned SDRAM access, one read outstanding
//   master_writedata/readdata    4 squares per word, little-endian lanes
//   master_waitrequest           SDRAM stall
//   master_readdatavalid         read data valid
module leaper_movegen #(
  parameter int BOARD_W   = 8,
  parameter int ADDR_W    = 32,
  parameter int MAX_MOVES = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              slave_waitrequest,
  input  logic [3:0]        slave_address,
  input  logic              slave_read,
  output logic [31:0]       slave_readdata,
  input  logic              slave_write,
  input  logic [31:0]       slave_writedata,
  input  logic              master_waitrequest,
  output logic [ADDR_W-1:0] master_address,
  output logic              master_read,
  input  logic [31:0]       master_readdata,
  input  logic              master_readdatavalid,
  output logic              master_write,
  output logic [31:0]       master_writedata
);
  localparam int SQ = BOARD_W * BOARD_W;
  localparam int NW = SQ / 4;
  localparam int WW = (NW > 1) ? $clog2(NW) : 1;
  localparam int SW = WW + 2;
  localparam int LW = $clog2(BOARD_W);
  localparam int CW = LW + 3;
  localparam int KW = $clog2(MAX_MOVES + 1);
  localparam logic signed [CW-1:0] BW_S = CW'(BOARD_W);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SCAN, S_EMIT, S_DONE} state_t;

  state_t            r_state;
  logic [31:0]       r_src, r_dst, r_x, r_y, r_mode, r_last;
  logic [KW-1:0]     r_count, r_k;
  logic [WW-1:0]     r_widx;
  logic              r_rd_wait;
  logic [31:0]       r_buf [NW];
  logic [SW-1:0]     r_tgt;
  logic [31:0]       w_mask_rd;

  // Offset table packed as {dx,dy}, 4-bit two's complement each.
  function automatic logic [7:0] offs(input logic king, input logic [2:0] k);
    case ({king, k})
      4'b0000: return 8'h12;  4'b0001: return 8'h21;
      4'b0010: return 8'h2F;  4'b0011: return 8'h1E;
      4'b0100: return 8'hFE;  4'b0101: return 8'hEF;
      4'b0110: return 8'hE1;  4'b0111: return 8'hF2;
      4'b1000: return 8'h01;  4'b1001: return 8'h11;
      4'b1010: return 8'h10;  4'b1011: return 8'h1F;
      4'b1100: return 8'h0F;  4'b1101: return 8'hFF;
      4'b1110: return 8'hF0;  default: return 8'hF1;
    endcase
  endfunction

  function automatic logic [7:0] sq_byte(input logic [SW-1:0] s);
    logic [31:0] wd;
    wd = r_buf[s[SW-1:2]];
    return wd[{s[1:0], 3'b000} +: 8];
  endfunction

  // Successor word: buffer copy with the source square vacated and the mover
  // placed on the target square.
  function automatic logic [31:0] emit_word(input logic [WW-1:0] w,
                                            input logic [SW-1:0] s_sq,
                                            input logic [SW-1:0] t_sq,
                                            input logic [7:0]    mv);
    logic [31:0] d;
    d = r_buf[w];
    for (int l = 0; l < 4; l++) begin
      if ({w, 2'(l)} == s_sq) d[8*l +: 8] = 8'h00;
      if ({w, 2'(l)} == t_sq) d[8*l +: 8] = mv;
    end
    return d;
  endfunction

  logic [7:0]             w_off;
  logic signed [3:0]      w_dx4, w_dy4;
  logic signed [CW-1:0]   w_tx, w_ty;
  logic [SW-1:0]          w_src_sq, w_tsq;
  logic signed [7:0]      w_mover, w_tpiece;
  logic                   w_src_ok, w_inb, w_legal;

  assign w_off    = offs(r_mode == 32'd1, r_k[2:0]);
  assign w_dx4    = w_off[7:4];
  assign w_dy4    = w_off[3:0];
  assign w_tx     = signed'({3'b000, r_x[LW-1:0]}) + {{(CW-4){w_dx4[3]}}, w_dx4};
  assign w_ty     = signed'({3'b000, r_y[LW-1:0]}) + {{(CW-4){w_dy4[3]}}, w_dy4};
  assign w_src_sq = SW'(r_y[LW-1:0]) * SW'(BOARD_W) + SW'(r_x[LW-1:0]);
  assign w_tsq    = SW'(w_ty[LW-1:0]) * SW'(BOARD_W) + SW'(w_tx[LW-1:0]);
  assign w_mover  = sq_byte(w_src_sq);
  assign w_tpiece = sq_byte(w_tsq);
  assign w_src_ok = (r_x < 32'(BOARD_W)) && (r_y < 32'(BOARD_W)) && (w_mover != 8'sd0);
  assign w_inb    = !w_tx[CW-1] && !w_ty[CW-1] && (w_tx < BW_S) && (w_ty < BW_S);
  // Mover is non-zero here, so differing sign bits on a non-empty target mean a capture.
  assign w_legal  = w_inb && ((w_tpiece == 8'sd0) || (w_tpiece[7] != w_mover[7]));

`ifdef LEAPER_CAPTURE_MASK_EN
  logic [7:0] r_mask;
  logic       w_capt;
  assign w_capt    = (w_tpiece != 8'sd0);
  assign w_mask_rd = {24'd0, r_mask};
`else
  assign w_mask_rd = 32'd0;
`endif

  // A register-0 read stalls until the run reaches DONE; everything else is single-cycle.
  always_comb begin
    slave_waitrequest = 1'b0;
    if (slave_read && !slave_write && (slave_address == 4'd0) &&
        (r_state != S_IDLE) && (r_state != S_DONE))
      slave_waitrequest = 1'b1;
  end

  always_comb begin
    slave_readdata = 32'd0;
    if (slave_read) begin
      case (slave_address)
        4'd0:    slave_readdata = 32'(r_count);
        4'd1:    slave_readdata = r_src;
        4'd2:    slave_readdata = r_dst;
        4'd3:    slave_readdata = r_x;
        4'd4:    slave_readdata = r_y;
        4'd5:    slave_readdata = r_mode;
        4'd6:    slave_readdata = r_last;
        4'd7:    slave_readdata = w_mask_rd;
        default: slave_readdata = 32'd0;
      endcase
    end
  end

  // Board buffer and latched target square carry no reset.
  always_ff @(posedge clk) begin
    if (r_state == S_FETCH && r_rd_wait && master_readdatavalid)
      r_buf[r_widx] <= master_readdata;
    if (r_state == S_SCAN && w_src_ok && (r_k != KW'(MAX_MOVES)) && w_legal)
      r_tgt <= w_tsq;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= S_IDLE;
      r_src            <= '0;
      r_dst            <= '0;
      r_x              <= '0;
      r_y              <= '0;
      r_mode           <= '0;
      r_last           <= '0;
      r_count          <= '0;
      r_k              <= '0;
      r_widx           <= '0;
      r_rd_wait        <= 1'b0;
      master_read      <= 1'b0;
      master_write     <= 1'b0;
      master_address   <= '0;
      master_writedata <= '0;
`ifdef LEAPER_CAPTURE_MASK_EN
      r_mask           <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (slave_write) begin
            case (slave_address)
              4'd0: begin
                r_state        <= S_FETCH;
                r_count        <= '0;
                r_widx         <= '0;
                r_rd_wait      <= 1'b0;
                master_read    <= 1'b1;
                master_address <= ADDR_W'(r_src);
`ifdef LEAPER_CAPTURE_MASK_EN
                r_mask         <= '0;
`endif
              end
              4'd1: r_src  <= slave_writedata;
              4'd2: r_dst  <= slave_writedata;
              4'd3: r_x    <= slave_writedata;
              4'd4: r_y    <= slave_writedata;
              4'd5: r_mode <= slave_writedata;
              default: ;
            endcase
          end
        end
        S_FETCH: begin
          if (master_read && !master_waitrequest) begin
            master_read <= 1'b0;
            r_rd_wait   <= 1'b1;
          end
          if (r_rd_wait && master_readdatavalid) begin
            r_rd_wait <= 1'b0;
            if (r_widx == WW'(NW - 1)) begin
              r_state <= S_SCAN;
              r_k     <= '0;
            end else begin
              r_widx         <= r_widx + WW'(1);
              master_read    <= 1'b1;
              master_address <= master_address + ADDR_W'(4);
            end
          end
        end
        S_SCAN: begin
          if (!w_src_ok || (r_k == KW'(MAX_MOVES))) begin
            r_state <= S_DONE;
          end else begin
            r_k <= r_k + KW'(1);
            if (w_legal) begin
              r_state          <= S_EMIT;
              r_widx           <= '0;
              master_write     <= 1'b1;
              master_address   <= ADDR_W'(r_dst) + ADDR_W'(r_count) * ADDR_W'(SQ);
              master_writedata <= emit_word(WW'(0), w_src_sq, w_tsq, w_mover);
`ifdef LEAPER_CAPTURE_MASK_EN
              r_mask[r_count[2:0]] <= w_capt;
`endif
            end
          end
        end
        S_EMIT: begin
          if (!master_waitrequest) begin
            if (r_widx == WW'(NW - 1)) begin
              master_write <= 1'b0;
              r_count      <= r_count + KW'(1);
              r_state      <= S_SCAN;
            end else begin
              r_widx           <= r_widx + WW'(1);
              master_address   <= master_address + ADDR_W'(4);
              master_writedata <= emit_word(r_widx + WW'(1), w_src_sq, r_tgt, w_mover);
            end
          end
        end
        S_DONE: begin
          r_last  <= 32'(r_count);
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_leaper_movegen.sv
// Self-checking bench for leaper_movegen (8x8 board). SDRAM is a byte array
// with random stall; expected boards come from a move-list reference model.
module tb_leaper_movegen;
  localparam int SRC = 32'h100;
  localparam int DST = 32'h400;

  logic        clk = 1'b0;
  logic        rst;
  logic        slave_waitrequest;
  logic [3:0]  slave_address;
  logic        slave_read, slave_write;
  logic [31:0] slave_readdata, slave_writedata;
  logic        master_waitrequest;
  logic [31:0] master_address;
  logic        master_read, master_write;
  logic [31:0] master_readdata, master_writedata;
  logic        master_readdatavalid;

  leaper_movegen #(.BOARD_W(8), .ADDR_W(32), .MAX_MOVES(8)) dut (
    .clk(clk), .rst(rst),
    .slave_waitrequest(slave_waitrequest), .slave_address(slave_address),
    .slave_read(slave_read), .slave_readdata(slave_readdata),
    .slave_write(slave_write), .slave_writedata(slave_writedata),
    .master_waitrequest(master_waitrequest), .master_address(master_address),
    .master_read(master_read), .master_readdata(master_readdata),
    .master_readdatavalid(master_readdatavalid), .master_write(master_write),
    .master_writedata(master_writedata));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- SDRAM model ----------------
  logic [7:0]  mem [4096];
  bit          stall_en = 1'b0;
  bit          rd_pend = 1'b0;
  int          rd_addr;
  int          wr_cnt = 0;
  int          last_rdv_cyc = 0;
  bit          wr_hold = 1'b0;
  logic [31:0] hold_addr, hold_data;

  always @(negedge clk) begin
    master_readdatavalid = 1'b0;
    if (rst) begin
      rd_pend = 1'b0;
      wr_hold = 1'b0;
      master_waitrequest = 1'b0;
    end else begin
      if (rd_pend) begin
        master_readdatavalid = 1'b1;
        master_readdata = {mem[(rd_addr+3) & 4095], mem[(rd_addr+2) & 4095],
                           mem[(rd_addr+1) & 4095], mem[rd_addr & 4095]};
        rd_pend = 1'b0;
        last_rdv_cyc = cyc;
      end
      if (wr_hold) begin
        check("wr_hold_req", 512'(master_write), 512'(1));
        check("wr_hold_addr", 512'(master_address), 512'(hold_addr));
        check("wr_hold_data", 512'(master_writedata), 512'(hold_data));
      end
      wr_hold = 1'b0;
      master_waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
      if (master_read && !master_waitrequest) begin
        rd_pend = 1'b1;
        rd_addr = int'(master_address);
      end
      if (master_write) begin
        if (master_waitrequest) begin
          wr_hold = 1'b1;
          hold_addr = master_address;
          hold_data = master_writedata;
        end else begin
          check("wr_align", 512'(master_address[1:0]), 512'(0));
          for (int l = 0; l < 4; l++)
            mem[(int'(master_address) + l) & 4095] = master_writedata[8*l +: 8];
          wr_cnt++;
        end
      end
    end
  end

  function automatic logic [511:0] mem_board(input int a);
    logic [511:0] b;
    for (int s = 0; s < 64; s++) b[8*s +: 8] = mem[(a + s) & 4095];
    return b;
  endfunction

  task automatic load_board(input int a, input logic [511:0] b);
    for (int s = 0; s < 64; s++) mem[(a + s) & 4095] = b[8*s +: 8];
  endtask

  // ---------------- reference model ----------------
  int kn_dx[8] = '{1, 2, 2, 1, -1, -2, -2, -1};
  int kn_dy[8] = '{2, 1, -1, -2, -2, -1, 1, 2};
  int kg_dx[8] = '{0, 1, 1, 1, 0, -1, -1, -1};
  int kg_dy[8] = '{1, 1, 0, -1, -1, -1, 0, 1};
  logic [511:0] exp_b [8];
  int           exp_n;
  logic [7:0]   exp_mask;

  task automatic ref_model(input logic [511:0] b, input int x, input int y, input int mode);
    int mv, tg, tx, ty, dx, dy;
    logic [511:0] nb;
    exp_n = 0;
    exp_mask = 8'h00;
    if (x >= 0 && x < 8 && y >= 0 && y < 8) begin
      mv = $signed(b[8*(y*8+x) +: 8]);
      if (mv != 0) begin
        for (int k = 0; k < 8; k++) begin
          dx = (mode == 1) ? kg_dx[k] : kn_dx[k];
          dy = (mode == 1) ? kg_dy[k] : kn_dy[k];
          tx = x + dx;
          ty = y + dy;
          if (tx >= 0 && tx < 8 && ty >= 0 && ty < 8) begin
            tg = $signed(b[8*(ty*8+tx) +: 8]);
            if (tg == 0 || (tg < 0) != (mv < 0)) begin
              nb = b;
              nb[8*(y*8+x) +: 8] = 8'h00;
              nb[8*(ty*8+tx) +: 8] = 8'(mv);
              exp_b[exp_n] = nb;
              if (tg != 0) exp_mask[exp_n] = 1'b1;
              exp_n++;
            end
          end
        end
      end
    end
  endtask

  // ---------------- CPU tasks ----------------
  task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk); #1;
    slave_address = a; slave_writedata = d; slave_write = 1'b1;
    @(negedge clk); #1;
    slave_write = 1'b0;
  endtask

  task automatic cpu_read(input logic [3:0] a, output logic [31:0] d, output int done_cyc);
    int n = 0;
    @(negedge clk); #1;
    slave_address = a; slave_read = 1'b1;
    #1;
    while (slave_waitrequest === 1'b1 && n < 5000) begin
      @(negedge clk); #2;
      n++;
    end
    check("rd_wait_bound", 512'(slave_waitrequest), 512'(0));
    d = slave_readdata;
    done_cyc = cyc;
    @(posedge clk); #1;
    slave_read = 1'b0;
  endtask

  logic [511:0] got_b [8];
  int last_dc;

  task automatic do_run(input string tag, input logic [511:0] b, input int x, input int y, input int mode);
    logic [31:0] cnt, r6, r7;
    int dc;
    load_board(SRC, b);
    for (int i = 0; i < 512; i++) mem[DST + i] = 8'hEE;
    wr_cnt = 0;
    ref_model(b, x, y, mode);
    cpu_write(1, SRC); cpu_write(2, DST);
    cpu_write(3, 32'(x)); cpu_write(4, 32'(y)); cpu_write(5, 32'(mode));
    cpu_write(0, 32'd1);
    cpu_read(0, cnt, dc);
    last_dc = dc;
    check({tag, " count"}, 512'(cnt), 512'(exp_n));
    cpu_read(6, r6, dc);
    check({tag, " reg6"}, 512'(r6), 512'(exp_n));
    check({tag, " writes"}, 512'(wr_cnt), 512'(exp_n * 16));
    for (int k = 0; k < exp_n; k++) begin
      got_b[k] = mem_board(DST + 64 * k);
      check($sformatf("%s board%0d", tag, k), got_b[k], exp_b[k]);
    end
    check({tag, " src_intact"}, mem_board(SRC), b);
    cpu_read(7, r7, dc);
`ifdef LEAPER_CAPTURE_MASK_EN
    check({tag, " mask"}, 512'(r7), 512'(exp_mask));
`else
    check({tag, " reg7"}, 512'(r7), 512'(0));
`endif
  endtask

  function automatic logic [511:0] put(input logic [511:0] b, input int x, input int y, input int v);
    logic [511:0] r;
    r = b;
    r[8*(y*8+x) +: 8] = 8'(v);
    return r;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] b, sv_b [8];
    logic [31:0] rd;
    int dc, n, x, y, mode, sv_n;
    bit seen;

    rst = 1'b1;
    slave_address = 4'd0; slave_read = 1'b0; slave_write = 1'b0; slave_writedata = 32'd0;
    master_waitrequest = 1'b0; master_readdatavalid = 1'b0; master_readdata = 32'd0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst master_read", 512'(master_read), 512'(0));
    check("rst master_write", 512'(master_write), 512'(0));
    check("rst master_address", 512'(master_address), 512'(0));
    check("rst slave_waitrequest", 512'(slave_waitrequest), 512'(0));
    #1 rst = 1'b0;
    cpu_read(6, rd, dc);
    check("rst reg6", 512'(rd), 512'(0));
    cpu_read(0, rd, dc);
    check("rst reg0", 512'(rd), 512'(0));

    // Knight at (1,0) with its own pawns on the rest of the home row.
    b = '0;
    for (int i = 0; i < 8; i++) if (i != 1) b = put(b, i, 0, 1);
    b = put(b, 1, 0, 3);
    do_run("knight_home", b, 1, 0, 0);
    check("knight_home n3", 512'(exp_n), 512'(3));
    check("knight_home tgt22", 512'(got_b[0][8*(2*8+2) +: 8]), 512'(3));
    check("knight_home tgt31", 512'(got_b[1][8*(1*8+3) +: 8]), 512'(3));
    check("knight_home tgt02", 512'(got_b[2][8*(2*8+0) +: 8]), 512'(3));

    // King in the centre of an empty board.
    b = put('0, 4, 4, 5);
    do_run("king_centre", b, 4, 4, 1);
    check("king_centre n8", 512'(exp_n), 512'(8));
    check("king_centre k0", 512'(got_b[0][8*(5*8+4) +: 8]), 512'(5));
    check("king_centre k5", 512'(got_b[5][8*(3*8+3) +: 8]), 512'(5));

    // Corner knight: one capture, one blocked by own pawn.
    b = put('0, 0, 0, 3);
    b = put(b, 1, 2, -1);
    b = put(b, 2, 1, 1);
    do_run("corner_capture", b, 0, 0, 0);
    check("corner_capture n1", 512'(exp_n), 512'(1));
    check("corner_capture mask", 512'(exp_mask), 512'(1));

    // Empty source square: nothing emitted, prompt completion.
    b = put('0, 2, 2, 4);
    do_run("empty_src", b, 3, 3, 0);
    check("empty_src prompt", 512'((last_dc - last_rdv_cyc) <= 5), 512'(1));

    // Off-board coordinate and unknown mode value.
    b = put('0, 1, 1, -2);
    do_run("x_oob", b, 9, 1, 1);
    do_run("mode2_knight", b, 1, 1, 2);

    // Random boards, zero-stall then random-stall, both against the model.
    for (int it = 0; it < 6; it++) begin
      b = '0;
      for (int s = 0; s < 64; s++) begin
        n = $urandom_range(0, 3);
        if (n == 1) b[8*s +: 8] = 8'($urandom_range(1, 6));
        else if (n == 2) b[8*s +: 8] = 8'(-int'($urandom_range(1, 6)));
      end
      x = $urandom_range(0, 7);
      y = $urandom_range(0, 7);
      mode = $urandom_range(0, 2);
      b = put(b, x, y, ($urandom_range(0, 1) != 0) ? 2 : -2);
      stall_en = 1'b0;
      do_run($sformatf("rand%0d_nostall", it), b, x, y, mode);
      sv_n = exp_n;
      for (int k = 0; k < 8; k++) sv_b[k] = got_b[k];
      stall_en = 1'b1;
      do_run($sformatf("rand%0d_stall", it), b, x, y, mode);
      for (int k = 0; k < sv_n; k++)
        check($sformatf("rand%0d same%0d", it, k), got_b[k], sv_b[k]);
      stall_en = 1'b0;
    end

    // Reset in the middle of EMIT, then a clean rerun.
    b = put('0, 4, 4, -5);
    load_board(SRC, b);
    stall_en = 1'b1;
    cpu_write(1, SRC); cpu_write(2, DST); cpu_write(3, 4); cpu_write(4, 4); cpu_write(5, 1);
    cpu_write(0, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (master_write) seen = 1'b1;
    end
    check("rst_emit reached", 512'(seen), 512'(1));
    #3 rst = 1'b1;
    #1;
    check("rst_emit write_low", 512'(master_write), 512'(0));
    check("rst_emit read_low", 512'(master_read), 512'(0));
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    stall_en = 1'b0;
    cpu_read(6, rd, dc);
    check("rst_emit reg6", 512'(rd), 512'(0));
    stall_en = 1'b1;
    do_run("rst_rerun", b, 4, 4, 1);
    stall_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
